// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared handshake/command encodings for the USB endpoint controller
package usb_pkg;

    typedef enum logic [1:0] {
        HS_ACK   = 2'b00,
        HS_NONE  = 2'b01,
        HS_NAK   = 2'b10,
        HS_STALL = 2'b11
    } hs_e;

    typedef enum logic [2:0] {
        OP_ARM_IN     = 3'd0,
        OP_ARM_OUT    = 3'd1,
        OP_STALL_SET  = 3'd2,
        OP_STALL_CLR  = 3'd3,
        OP_TOGGLE_RST = 3'd4
    } cmd_op_e;

    function automatic int epw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usb_ep_regs.sv
// rtl/usb_ep_regs.sv - state of one endpoint: toggle, stall, IN/OUT arming and IN length
module usb_ep_regs
    import usb_pkg::*;
#(
    parameter int MAX_PKT = 64,
    parameter int LW      = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          succ_i,
    input  logic          succ_in_i,
    input  logic          succ_setup_i,
    input  logic          cmd_i,
    input  logic [2:0]    cmd_op_i,
    input  logic [LW-1:0] cmd_len_i,
    output logic          toggle_o,
    output logic          stall_o,
    output logic          in_armed_o,
    output logic          out_armed_o,
    output logic [LW-1:0] in_len_o
);

    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT);

    logic          toggle_q, toggle_d;
    logic          stall_q, stall_d;
    logic          in_armed_q, in_armed_d;
    logic          out_armed_q, out_armed_d;
    logic [LW-1:0] in_len_q, in_len_d;

    // A completed transaction has priority; the top rejects a same-endpoint command
    always_comb begin
        toggle_d    = toggle_q;
        stall_d     = stall_q;
        in_armed_d  = in_armed_q;
        out_armed_d = out_armed_q;
        in_len_d    = in_len_q;
        if (succ_i) begin
            if (succ_setup_i) begin
                toggle_d    = 1'b1;
                stall_d     = 1'b0;
                out_armed_d = 1'b0;
            end else begin
                toggle_d = !toggle_q;
                if (succ_in_i) begin
                    in_armed_d = 1'b0;
                end else begin
                    out_armed_d = 1'b0;
                end
            end
        end else if (cmd_i) begin
            case (cmd_op_e'(cmd_op_i))
                OP_ARM_IN: begin
                    in_armed_d = 1'b1;
                    in_len_d   = (cmd_len_i > MAX_LEN) ? MAX_LEN : cmd_len_i;
                end
                OP_ARM_OUT:    out_armed_d = 1'b1;
                OP_STALL_SET:  stall_d = 1'b1;
                OP_STALL_CLR: begin
                    stall_d  = 1'b0;
                    toggle_d = 1'b0;
                end
                OP_TOGGLE_RST: toggle_d = 1'b0;
                default: ;
            endcase
        end
        if (clr_i) begin
            toggle_d    = 1'b0;
            stall_d     = 1'b0;
            in_armed_d  = 1'b0;
            out_armed_d = 1'b0;
            in_len_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            toggle_q    <= 1'b0;
            stall_q     <= 1'b0;
            in_armed_q  <= 1'b0;
            out_armed_q <= 1'b0;
            in_len_q    <= '0;
        end else begin
            toggle_q    <= toggle_d;
            stall_q     <= stall_d;
            in_armed_q  <= in_armed_d;
            out_armed_q <= out_armed_d;
            in_len_q    <= in_len_d;
        end
    end

    assign toggle_o    = toggle_q;
    assign stall_o     = stall_q;
    assign in_armed_o  = in_armed_q;
    assign out_armed_o = out_armed_q;
    assign in_len_o    = in_len_q;

endmodule

// File: rtl/usb_ep_ctrl.sv
// rtl/usb_ep_ctrl.sv - USB device endpoint controller: handshakes, packet buffer access, app commands/events
module usb_ep_ctrl
    import usb_pkg::*;
#(
    parameter int NUM_EP  = 4,
    parameter int MAX_PKT = 64,
    localparam int EPW    = epw_of(NUM_EP),
    localparam int BAW    = $clog2(MAX_PKT),
    localparam int LW     = BAW + 1
) (
    input  logic               clk_48,
    input  logic               rst_n,
    input  logic               usb_rst,
    input  logic               transaction_active,
    input  logic [3:0]         endpoint,
    input  logic               direction_in,
    input  logic               setup,
    input  logic               success,
    input  logic               data_strobe,
    input  logic [7:0]         data_out,
    output logic               data_toggle,
    output logic [1:0]         handshake,
    output logic [7:0]         data_in,
    output logic               data_in_valid,
    output logic [EPW+BAW-1:0] ram_addr,
    output logic               ram_we,
    output logic [7:0]         ram_wdata,
    input  logic [7:0]         ram_rdata,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    input  logic [3:0]         cmd_ep,
    input  logic [LW-1:0]      cmd_len,
    output logic               cmd_err,
    input  logic [NUM_EP-1:0]  ep_enable,
    output logic               evt_valid,
    output logic [3:0]         evt_ep,
    output logic               evt_in,
    output logic               evt_setup,
    output logic [LW-1:0]      evt_len,
    output logic               evt_ovf
);

    localparam logic [4:0]    NUM_EP_L = 5'(NUM_EP);
    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_PKT);

    logic [NUM_EP-1:0] tog_v, stall_v, in_armed_v, out_armed_v;
    logic [LW-1:0]     in_len_v [NUM_EP];

    logic               ta_q;
    logic               abort_q, abort_d;
    logic [LW-1:0]      idx_q, idx_d;
    logic               ovf_q, ovf_d;
    logic               we_q, we_d;
    logic [EPW+BAW-1:0] waddr_q, waddr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               cmd_err_q, cmd_err_d;
    logic               evt_valid_q, evt_valid_d;
    logic [3:0]         evt_ep_q, evt_ep_d;
    logic               evt_in_q, evt_in_d;
    logic               evt_setup_q, evt_setup_d;
    logic [LW-1:0]      evt_len_q, evt_len_d;
    logic               evt_ovf_q, evt_ovf_d;

    logic [EPW-1:0] ep_sel;
    logic           ep_ok, is_in;
    logic           cur_tog, cur_stall, cur_in_armed, cur_out_armed;
    logic [LW-1:0]  cur_in_len;
    hs_e            hs;
    logic           rise, full, strobe_ok, ovf_cur, ovf_nxt;
    logic [LW-1:0]  idx_cur, idx_nxt;
    logic           succ_apply, cmd_bad, cmd_accept;

    always_comb begin
        ep_sel        = endpoint[EPW-1:0];
        ep_ok         = ({1'b0, endpoint} < NUM_EP_L) && ep_enable[ep_sel];
        is_in         = direction_in && !setup;
        cur_tog       = 1'b0;
        cur_stall     = 1'b0;
        cur_in_armed  = 1'b0;
        cur_out_armed = 1'b0;
        cur_in_len    = '0;
        if (ep_ok) begin
            cur_tog       = tog_v[ep_sel];
            cur_stall     = stall_v[ep_sel];
            cur_in_armed  = in_armed_v[ep_sel];
            cur_out_armed = out_armed_v[ep_sel];
            cur_in_len    = in_len_v[ep_sel];
        end
        if (!ep_ok) begin
            hs = HS_NONE;
        end else if (setup) begin
            hs = HS_ACK;
        end else if (cur_stall) begin
            hs = HS_STALL;
        end else if (is_in) begin
            hs = cur_in_armed ? HS_ACK : HS_NAK;
        end else begin
            hs = cur_out_armed ? HS_ACK : HS_NAK;
        end
    end

    // The rising edge of transaction_active restarts the byte index in the same cycle
    always_comb begin
        rise       = transaction_active && !ta_q;
        idx_cur    = rise ? '0 : idx_q;
        ovf_cur    = rise ? 1'b0 : ovf_q;
        full       = (idx_cur == MAX_LEN);
        strobe_ok  = data_strobe && transaction_active && ep_ok && !abort_q;
        idx_nxt    = idx_cur + {{(LW-1){1'b0}}, (strobe_ok && !full)};
        ovf_nxt    = ovf_cur || (strobe_ok && full && !is_in);
        succ_apply = success && !abort_q && (hs == HS_ACK);
        cmd_bad    = cmd_valid && (({1'b0, cmd_ep} >= NUM_EP_L) ||
                     ((transaction_active || success) && (cmd_ep == endpoint)));
        cmd_accept = cmd_valid && !cmd_bad;

        abort_d     = abort_q && transaction_active;
        idx_d       = idx_nxt;
        ovf_d       = ovf_nxt;
        we_d        = strobe_ok && !is_in && !full;
        waddr_d     = {ep_sel, idx_cur[BAW-1:0]};
        wdata_d     = data_out;
        cmd_err_d   = cmd_bad;
        evt_valid_d = succ_apply;
        evt_ep_d    = evt_ep_q;
        evt_in_d    = evt_in_q;
        evt_setup_d = evt_setup_q;
        evt_len_d   = evt_len_q;
        evt_ovf_d   = evt_ovf_q;
        if (succ_apply) begin
            evt_ep_d    = endpoint;
            evt_in_d    = is_in;
            evt_setup_d = setup;
            evt_len_d   = is_in ? cur_in_len : idx_nxt;
            evt_ovf_d   = ovf_nxt;
        end
        if (usb_rst) begin
            abort_d     = transaction_active;
            idx_d       = '0;
            ovf_d       = 1'b0;
            we_d        = 1'b0;
            cmd_err_d   = 1'b0;
            evt_valid_d = 1'b0;
            evt_ep_d    = '0;
            evt_in_d    = 1'b0;
            evt_setup_d = 1'b0;
            evt_len_d   = '0;
            evt_ovf_d   = 1'b0;
        end
    end

    // abort_q resets high so a transaction already in flight at reset release never completes
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            ta_q        <= 1'b0;
            abort_q     <= 1'b1;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cmd_err_q   <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_ep_q    <= '0;
            evt_in_q    <= 1'b0;
            evt_setup_q <= 1'b0;
            evt_len_q   <= '0;
            evt_ovf_q   <= 1'b0;
        end else begin
            ta_q        <= transaction_active;
            abort_q     <= abort_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cmd_err_q   <= cmd_err_d;
            evt_valid_q <= evt_valid_d;
            evt_ep_q    <= evt_ep_d;
            evt_in_q    <= evt_in_d;
            evt_setup_q <= evt_setup_d;
            evt_len_q   <= evt_len_d;
            evt_ovf_q   <= evt_ovf_d;
        end
    end

    for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
        localparam logic [3:0] EP_ID = 4'(i);
        usb_ep_regs #(
            .MAX_PKT (MAX_PKT),
            .LW      (LW)
        ) u_regs (
            .clk_i        (clk_48),
            .rst_ni       (rst_n),
            .clr_i        (usb_rst),
            .succ_i       (succ_apply && (endpoint == EP_ID)),
            .succ_in_i    (is_in),
            .succ_setup_i (setup),
            .cmd_i        (cmd_accept && (cmd_ep == EP_ID)),
            .cmd_op_i     (cmd_op),
            .cmd_len_i    (cmd_len),
            .toggle_o     (tog_v[i]),
            .stall_o      (stall_v[i]),
            .in_armed_o   (in_armed_v[i]),
            .out_armed_o  (out_armed_v[i]),
            .in_len_o     (in_len_v[i])
        );
    end

    assign handshake     = hs;
    assign data_toggle   = ep_ok && !setup && cur_tog;
    assign data_in       = ram_rdata;
    assign data_in_valid = transaction_active && ep_ok && is_in && cur_in_armed &&
                           !cur_stall && (idx_cur < cur_in_len);
    assign ram_addr      = we_q ? waddr_q : {ep_sel, idx_cur[BAW-1:0]};
    assign ram_we        = we_q;
    assign ram_wdata     = wdata_q;
    assign cmd_err       = cmd_err_q;
    assign evt_valid     = evt_valid_q;
    assign evt_ep        = evt_ep_q;
    assign evt_in        = evt_in_q;
    assign evt_setup     = evt_setup_q;
    assign evt_len       = evt_len_q;
    assign evt_ovf       = evt_ovf_q;

endmodule
